// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES equal
// slices, one register stage per slice, with a global-stall valid/ready handshake.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow
);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  localparam int unsigned SLICE = WIDTH / STAGES;

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_y [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic             r_cmsb;

  logic [WIDTH-1:0] w_ain  [STAGES];
  logic [WIDTH-1:0] w_bin  [STAGES];
  logic [WIDTH-1:0] w_yin  [STAGES];
  logic [WIDTH-1:0] w_yout [STAGES];
  logic [SLICE:0]   w_sum  [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_cout;
  logic             w_cmsb;
  logic             w_adv;

  assign w_adv     = ~r_v[STAGES-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[STAGES-1];
  assign y         = r_y[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign overflow  = r_cmsb ^ r_c[STAGES-1];

  always_comb begin
    w_ain[0] = a;
    w_bin[0] = sub ? ~b : b;
    w_cin    = '0;
    w_vin    = '0;
    w_cin[0] = cin ^ sub;
    w_vin[0] = in_valid;
    w_yin[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_ain[k] = r_a[k-1];
      w_bin[k] = r_b[k-1];
      w_cin[k] = r_c[k-1];
      w_vin[k] = r_v[k-1];
      w_yin[k] = r_y[k-1];
    end
    w_cout = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_sum[k]  = {1'b0, w_ain[k][k*SLICE +: SLICE]} + {1'b0, w_bin[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, w_cin[k]};
      w_yout[k] = w_yin[k];
      w_yout[k][k*SLICE +: SLICE] = w_sum[k][SLICE-1:0];
      w_cout[k] = w_sum[k][SLICE];
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
    w_cmsb = w_yout[STAGES-1][WIDTH-1] ^ w_ain[STAGES-1][WIDTH-1] ^ w_bin[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_y[k] <= '0;
      end
      r_c    <= '0;
      r_v    <= '0;
      r_cmsb <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k] <= w_ain[k];
        r_b[k] <= w_bin[k];
        r_y[k] <= w_yout[k];
      end
      r_c    <= w_cout;
      r_v    <= w_vin;
      r_cmsb <= w_cmsb;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (16-bit/4-stage instance plus
// an exhaustive 4-bit/1-stage instance).
module tb_pipelined_addsub;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, y;
  logic          cin, sub, cout, overflow;

  logic          x_in_valid, x_in_ready, x_out_valid, x_out_ready;
  logic [3:0]    x_a, x_b, x_y;
  logic          x_cin, x_sub, x_cout, x_overflow;

  int            n_run  = 0;
  int            n_fail = 0;

  logic [3:0]    x_bp;
  logic [4:0]    x_sum;
  logic          x_eovf;
  logic [17:0]   prev;
  logic          prev_stall, acc_in;
  int            j, k;

  logic [15:0] t5_a [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                            16'h4444, 16'h5555, 16'h6666, 16'h7777};
  logic [15:0] t5_y [8] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434,
                            16'h4545, 16'h5656, 16'h6767, 16'h7878};

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .overflow(overflow)
  );

  pipelined_addsub #(.WIDTH(4), .STAGES(1)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(x_out_valid),
    .out_ready(x_out_ready), .y(x_y), .cout(x_cout), .overflow(x_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic single_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                           input logic op_cin, input logic op_sub,
                           input logic e_ovf, input logic e_cout, input logic [15:0] e_y);
    a = op_a; b = op_b; cin = op_cin; sub = op_sub; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      @(negedge clk);
      check({tag, "_lat"}, 32'(out_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check(tag, {14'd0, overflow, cout, y}, {14'd0, e_ovf, e_cout, e_y});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    x_in_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0; x_out_ready = 1'b1;
    #2;
    check("rst_out", {14'd0, overflow, cout, y}, 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    single_op("t1_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000);
    single_op("t2_carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    single_op("t2_cin",     16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    single_op("t3_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE);
    single_op("t3_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7FFF);
    single_op("t3_borrow",  16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
    single_op("t3_zero",    16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    single_op("t1_posovf",  16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000);

    fork
      begin : t4_drv
        for (int i = 0; i < 8; i++) begin
          a = 16'(i); b = 16'(i << 8); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
          @(negedge clk);
          check("t4_in_ready", 32'(in_ready), 32'd1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : t4_mon
        for (int c = 0; c < 13; c++) begin
          @(negedge clk);
          check("t4_valid", 32'(out_valid), 32'(c >= 4 && c <= 11));
          if (c >= 4 && c <= 11)
            check("t4_y", {14'd0, overflow, cout, y}, {16'd0, 16'((c - 4) * 257)});
          @(posedge clk);
        end
      end
    join
    #1;

    j = 0; k = 0; prev = '0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      in_valid = (j < 8);
      a = (j < 8) ? t5_a[j] : 16'h0000;
      b = 16'h0101; cin = 1'b0; sub = 1'b0;
      out_ready = !(cyc >= 6 && cyc <= 8);
      @(negedge clk);
      acc_in = in_valid && in_ready;
      if (!out_ready) check("t5_stall_rdy", 32'(in_ready), 32'd0);
      if (prev_stall) check("t5_hold", {14'd0, overflow, cout, y}, {14'd0, prev});
      if (out_valid && out_ready) begin
        check("t5_y", {14'd0, overflow, cout, y}, {16'd0, t5_y[k]});
        k++;
      end
      prev = {overflow, cout, y};
      prev_stall = !out_ready;
      @(posedge clk); #1;
      if (acc_in) j++;
    end
    check("t5_count", 32'(k), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("t5_empty", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("t6_pre_vld", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_vld", 32'(out_valid), 32'd0);
    check("t6_rst_out", {14'd0, overflow, cout, y}, 32'd0);
    check("t6_rst_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_hold_vld", 32'(out_valid), 32'd0);
    check("t6_hold_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < S + 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t6_flushed", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    single_op("t6_after", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            x_a = 4'(ia); x_b = 4'(ib); x_cin = 1'(ic); x_sub = 1'(is); x_in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            x_bp   = x_sub ? ~x_b : x_b;
            x_sum  = {1'b0, x_a} + {1'b0, x_bp} + {4'd0, x_cin ^ x_sub};
            x_eovf = (x_a[3] == x_bp[3]) && (x_sum[3] != x_a[3]);
            check("exh_w4s1", {25'd0, x_out_valid, x_overflow, x_cout, x_y},
                  {25'd0, 1'b1, x_eovf, x_sum});
          end
    x_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
